// File: rtl/npu_csr_regfile_mc_if.sv
// APB3 completer bus bundle for the NPU CSR register file.
`timescale 1ns/1ps
interface npu_csr_regfile_mc_if #(
    parameter int APB_A_W = 32
);
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [APB_A_W-1:0] paddr;
    logic [31:0]        pwdata;
    logic [31:0]        prdata;
    logic               pready;
    logic               pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/npu_csr_regfile_mc.sv
// Multi-tensor APB3 CSR file for the NPU core: per-tensor working registers
// double-buffered into shadows at each job launch, plus a start/done job FSM
// with a one-deep pending-start queue, sticky DONE and a level interrupt.
`timescale 1ns/1ps

// One tensor descriptor channel: working copy (APB visible) and shadow copy
// (driven to the core). The shadow captures the post-write working value so a
// field written on the launch edge is part of the launched job.
module npu_csr_tensor #(
    parameter int APB_A_W = 32,
    parameter int DIM_W   = 11,
    parameter int I_LEN   = 8,
    parameter int M_LEN   = 32,
    parameter int SH_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [2:0]         i_fld,
    input  logic [31:0]        i_wdata,
    input  logic               i_launch,
    output logic [31:0]        o_rdata,
    output logic [APB_A_W-1:0] o_sh_addr,
    output logic [DIM_W-1:0]   o_sh_row,
    output logic [DIM_W-1:0]   o_sh_col,
    output logic [DIM_W-1:0]   o_sh_depth,
    output logic [I_LEN-1:0]   o_sh_zp,
    output logic [M_LEN-1:0]   o_sh_bias,
    output logic [M_LEN-1:0]   o_sh_scale,
    output logic [SH_W-1:0]    o_sh_shift
);
    logic [APB_A_W-1:0] r_addr,  r_sh_addr,  w_addr_nxt;
    logic [DIM_W-1:0]   r_row,   r_sh_row,   w_row_nxt;
    logic [DIM_W-1:0]   r_col,   r_sh_col,   w_col_nxt;
    logic [DIM_W-1:0]   r_depth, r_sh_depth, w_depth_nxt;
    logic [I_LEN-1:0]   r_zp,    r_sh_zp,    w_zp_nxt;
    logic [M_LEN-1:0]   r_bias,  r_sh_bias,  w_bias_nxt;
    logic [M_LEN-1:0]   r_scale, r_sh_scale, w_scale_nxt;
    logic [SH_W-1:0]    r_shift, r_sh_shift, w_shift_nxt;

    // Next working values: the addressed field takes the low bits of the write data
    always_comb begin
        w_addr_nxt  = r_addr;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_depth_nxt = r_depth;
        w_zp_nxt    = r_zp;
        w_bias_nxt  = r_bias;
        w_scale_nxt = r_scale;
        w_shift_nxt = r_shift;
        if (i_we) begin
            case (i_fld)
                3'd0: w_addr_nxt  = APB_A_W'(i_wdata);
                3'd1: w_row_nxt   = DIM_W'(i_wdata);
                3'd2: w_col_nxt   = DIM_W'(i_wdata);
                3'd3: w_depth_nxt = DIM_W'(i_wdata);
                3'd4: w_zp_nxt    = I_LEN'(i_wdata);
                3'd5: w_bias_nxt  = M_LEN'(i_wdata);
                3'd6: w_scale_nxt = M_LEN'(i_wdata);
                default: w_shift_nxt = SH_W'(i_wdata);
            endcase
        end
    end

    // Working registers follow writes; shadows reload only on launch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0; r_row      <= '0; r_col      <= '0; r_depth    <= '0;
            r_zp       <= '0; r_bias     <= '0; r_scale    <= '0; r_shift    <= '0;
            r_sh_addr  <= '0; r_sh_row   <= '0; r_sh_col   <= '0; r_sh_depth <= '0;
            r_sh_zp    <= '0; r_sh_bias  <= '0; r_sh_scale <= '0; r_sh_shift <= '0;
        end else begin
            r_addr  <= w_addr_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_depth <= w_depth_nxt;
            r_zp    <= w_zp_nxt;
            r_bias  <= w_bias_nxt;
            r_scale <= w_scale_nxt;
            r_shift <= w_shift_nxt;
            if (i_launch) begin
                r_sh_addr  <= w_addr_nxt;
                r_sh_row   <= w_row_nxt;
                r_sh_col   <= w_col_nxt;
                r_sh_depth <= w_depth_nxt;
                r_sh_zp    <= w_zp_nxt;
                r_sh_bias  <= w_bias_nxt;
                r_sh_scale <= w_scale_nxt;
                r_sh_shift <= w_shift_nxt;
            end
        end
    end

    // Readback of the working copy; signed fields are sign-extended
    always_comb begin
        case (i_fld)
            3'd0: o_rdata = 32'(r_addr);
            3'd1: o_rdata = 32'(r_row);
            3'd2: o_rdata = 32'(r_col);
            3'd3: o_rdata = 32'(r_depth);
            3'd4: o_rdata = 32'($signed(r_zp));
            3'd5: o_rdata = 32'($signed(r_bias));
            3'd6: o_rdata = 32'($signed(r_scale));
            default: o_rdata = 32'(r_shift);
        endcase
    end

    assign o_sh_addr  = r_sh_addr;
    assign o_sh_row   = r_sh_row;
    assign o_sh_col   = r_sh_col;
    assign o_sh_depth = r_sh_depth;
    assign o_sh_zp    = r_sh_zp;
    assign o_sh_bias  = r_sh_bias;
    assign o_sh_scale = r_sh_scale;
    assign o_sh_shift = r_sh_shift;
endmodule

module npu_csr_regfile_mc #(
    parameter int N_TENSOR = 3,
    parameter int APB_A_W  = 32,
    parameter int DIM_W    = 11,
    parameter int I_LEN    = 8,
    parameter int M_LEN    = 32,
    parameter int SH_W     = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    npu_csr_regfile_mc_if.slave         apb,
    output logic                        start_o,
    input  logic                        done_i,
    output logic                        busy_o,
    output logic                        irq_o,
    output logic [N_TENSOR*APB_A_W-1:0] cfg_addr_o,
    output logic [N_TENSOR*DIM_W-1:0]   cfg_row_o,
    output logic [N_TENSOR*DIM_W-1:0]   cfg_col_o,
    output logic [N_TENSOR*DIM_W-1:0]   cfg_depth_o,
    output logic [N_TENSOR*I_LEN-1:0]   cfg_zp_o,
    output logic [N_TENSOR*M_LEN-1:0]   cfg_bias_o,
    output logic [N_TENSOR*M_LEN-1:0]   cfg_scale_o,
    output logic [N_TENSOR*SH_W-1:0]    cfg_shift_o
);
    localparam int BLK_W = APB_A_W - 5;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN} state_t;

    state_t r_state;
    logic   r_start, r_busy, r_pending, r_done, r_irq_en;

    logic                         w_acc, w_glob, w_ten, w_err;
    logic                         w_wr_ok, w_rd_ok, w_start, w_clr, w_launch;
    logic [BLK_W-1:0]             w_blk, w_tidx;
    logic [1:0]                   w_goff;
    logic [2:0]                   w_fld;
    logic [31:0]                  w_rdata;
    logic [N_TENSOR-1:0]          w_ten_we;
    logic [N_TENSOR-1:0][31:0]    w_ten_rd;
    logic                         w_unused_lsb;

    // Address decode: 32-byte blocks; block 0 low half is the global map,
    // blocks 2.. are tensor channels.
    assign w_acc    = apb.psel & apb.penable;
    assign w_blk    = apb.paddr[APB_A_W-1:5];
    assign w_tidx   = w_blk - BLK_W'(2);
    assign w_glob   = (w_blk == '0) && !apb.paddr[4];
    assign w_ten    = (w_blk >= BLK_W'(2)) && (w_tidx < BLK_W'(N_TENSOR));
    assign w_goff   = apb.paddr[3:2];
    assign w_fld    = apb.paddr[4:2];
    assign w_unused_lsb = ^apb.paddr[1:0];

    // Error decode: unmapped, write to RO register, or START with the queue full
    always_comb begin
        w_err = 1'b0;
        if (w_acc) begin
            if (!w_glob && !w_ten) begin
                w_err = 1'b1;
            end else if (w_glob && apb.pwrite) begin
                if (w_goff == 2'd1 || w_goff == 2'd3)
                    w_err = 1'b1;
                else if (w_goff == 2'd0 && apb.pwdata[0] && r_pending)
                    w_err = 1'b1;
            end
        end
    end

    assign w_wr_ok = w_acc & apb.pwrite & ~w_err;
    assign w_rd_ok = w_acc & ~apb.pwrite & ~w_err;
    assign w_start = w_wr_ok & w_glob & (w_goff == 2'd0) & apb.pwdata[0];
    assign w_clr   = w_wr_ok & w_glob & (w_goff == 2'd2) & apb.pwdata[0];

    // Edges that enter LAUNCH: a start from IDLE, or a job end with a start
    // either already queued or arriving in the same cycle.
    assign w_launch = ((r_state == S_IDLE) && w_start) ||
                      ((r_state == S_RUN) && done_i && (r_pending || w_start));

    genvar t;
    generate
        for (t = 0; t < N_TENSOR; t++) begin : g_ten
            assign w_ten_we[t] = w_wr_ok & w_ten & (w_tidx == BLK_W'(t));
            npu_csr_tensor #(
                .APB_A_W(APB_A_W), .DIM_W(DIM_W), .I_LEN(I_LEN),
                .M_LEN(M_LEN), .SH_W(SH_W)
            ) u_ten (
                .clk       (clk),
                .rst       (rst),
                .i_we      (w_ten_we[t]),
                .i_fld     (w_fld),
                .i_wdata   (apb.pwdata),
                .i_launch  (w_launch),
                .o_rdata   (w_ten_rd[t]),
                .o_sh_addr (cfg_addr_o [t*APB_A_W +: APB_A_W]),
                .o_sh_row  (cfg_row_o  [t*DIM_W   +: DIM_W]),
                .o_sh_col  (cfg_col_o  [t*DIM_W   +: DIM_W]),
                .o_sh_depth(cfg_depth_o[t*DIM_W   +: DIM_W]),
                .o_sh_zp   (cfg_zp_o   [t*I_LEN   +: I_LEN]),
                .o_sh_bias (cfg_bias_o [t*M_LEN   +: M_LEN]),
                .o_sh_scale(cfg_scale_o[t*M_LEN   +: M_LEN]),
                .o_sh_shift(cfg_shift_o[t*SH_W    +: SH_W])
            );
        end
    endgenerate

    // Read mux: zero outside successful reads
    always_comb begin
        w_rdata = '0;
        if (w_rd_ok) begin
            if (w_glob) begin
                case (w_goff)
                    2'd0:    w_rdata = {30'd0, r_irq_en, 1'b0};
                    2'd1:    w_rdata = {29'd0, r_pending, r_done, r_busy};
                    2'd3:    w_rdata = {28'd0, 4'(N_TENSOR)};
                    default: w_rdata = '0;
                endcase
            end else begin
                for (int i = 0; i < N_TENSOR; i++)
                    if (w_tidx == BLK_W'(i)) w_rdata = w_ten_rd[i];
            end
        end
    end

    assign apb.prdata  = w_rdata;
    assign apb.pslverr = w_err;
    assign apb.pready  = 1'b1;

    // Job FSM with registered start/busy and the one-deep pending queue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_LAUNCH;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_RUN;
                    if (w_start) r_pending <= 1'b1;
                end
                S_RUN: begin
                    if (done_i) begin
                        r_pending <= 1'b0;
                        if (r_pending || w_start) begin
                            r_state <= S_LAUNCH;
                            r_start <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_start) begin
                        r_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky DONE (set beats clear) and the interrupt enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done   <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if ((r_state == S_RUN) && done_i) r_done <= 1'b1;
            else if (w_clr)                   r_done <= 1'b0;
            if (w_wr_ok && w_glob && (w_goff == 2'd0)) r_irq_en <= apb.pwdata[1];
        end
    end

    assign start_o = r_start;
    assign busy_o  = r_busy;
    assign irq_o   = r_done & r_irq_en;
endmodule

// File: tb/tb_npu_csr_regfile_mc.sv
// Bench for npu_csr_regfile_mc: directed table, hand sequences for the
// job-control corners, then random APB traffic against a reference model.
`timescale 1ns/1ps
module tb_npu_csr_regfile_mc;
    localparam int NT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done_i = 1'b0;
    logic start_o, busy_o, irq_o;
    logic [NT*32-1:0] cfg_addr_o, cfg_bias_o, cfg_scale_o;
    logic [NT*11-1:0] cfg_row_o, cfg_col_o, cfg_depth_o;
    logic [NT*8-1:0]  cfg_zp_o;
    logic [NT*5-1:0]  cfg_shift_o;

    npu_csr_regfile_mc_if #(.APB_A_W(32)) bus ();

    npu_csr_regfile_mc #(
        .N_TENSOR(NT), .APB_A_W(32), .DIM_W(11), .I_LEN(8), .M_LEN(32), .SH_W(5)
    ) dut (
        .clk(clk), .rst(rst), .apb(bus), .start_o(start_o), .done_i(done_i),
        .busy_o(busy_o), .irq_o(irq_o), .cfg_addr_o(cfg_addr_o),
        .cfg_row_o(cfg_row_o), .cfg_col_o(cfg_col_o), .cfg_depth_o(cfg_depth_o),
        .cfg_zp_o(cfg_zp_o), .cfg_bias_o(cfg_bias_o), .cfg_scale_o(cfg_scale_o),
        .cfg_shift_o(cfg_shift_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: register contents as plain arrays, job phase as
    // 0 = idle, 1 = launch cycle, 2 = running.
    logic [31:0] m_wk [NT][8];
    logic [31:0] m_sh [NT][8];
    int ph = 0;
    bit m_pend = 0, m_done = 0, m_en = 0;

    function automatic logic [31:0] fmask(input int f);
        case (f)
            1, 2, 3: return 32'h7FF;
            4:       return 32'hFF;
            7:       return 32'h1F;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NT; i++)
            for (int f = 0; f < 8; f++) begin
                m_wk[i][f] = '0;
                m_sh[i][f] = '0;
            end
        ph = 0; m_pend = 0; m_done = 0; m_en = 0;
    endtask

    // Expected response of one access phase, from the current model state
    task automatic m_dec(input bit w, input logic [31:0] a, input logic [31:0] d,
                         output bit err, output logic [31:0] rd, output int ti, output int f);
        logic [31:0] ab, off, v;
        bit valid;
        ab = {a[31:2], 2'b00};
        ti = -1; f = 0; rd = '0;
        if (ab < 32'h40) begin
            valid = (ab == 32'h0) || (ab == 32'h4) || (ab == 32'h8) || (ab == 32'hC);
        end else begin
            off = ab - 32'h40;
            valid = (off >> 5) < NT;
            if (valid) begin
                ti = int'(off >> 5);
                f  = int'(off[4:2]);
            end
        end
        err = !valid || (w && (ab == 32'h4 || ab == 32'hC)) ||
              (w && ab == 32'h0 && d[0] && m_pend);
        if (!w && !err) begin
            if (ti >= 0) begin
                v = m_wk[ti][f];
                if (f == 4 && v[7]) v = v | 32'hFFFF_FF00;
                rd = v;
            end else if (ab == 32'h0) rd = {30'd0, m_en, 1'b0};
            else if (ab == 32'h4) rd = {29'd0, m_pend, m_done, ph != 0};
            else if (ab == 32'hC) rd = NT;
        end
    endtask

    // Advance the model by one clock edge
    task automatic m_commit(input bit acc, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input bit dn, input bit r);
        bit err, wr, start, clr, launch;
        logic [31:0] rd;
        int ti, f;
        if (r) begin
            m_clear();
            return;
        end
        m_dec(w, a, d, err, rd, ti, f);
        wr    = acc && w && !err;
        start = wr && (a[31:2] == 30'h0) && d[0];
        clr   = wr && (a[31:2] == 30'h2) && d[0];
        if (wr && a[31:2] == 30'h0) m_en = d[1];
        if (wr && ti >= 0) m_wk[ti][f] = d & fmask(f);
        launch = (ph == 0 && start) || (ph == 2 && dn && (m_pend || start));
        if (ph == 2 && dn) m_done = 1;
        else if (clr)      m_done = 0;
        case (ph)
            0: if (start) ph = 1;
            1: begin ph = 2; if (start) m_pend = 1; end
            default: begin
                if (dn) begin ph = (m_pend || start) ? 1 : 0; m_pend = 0; end
                else if (start) m_pend = 1;
            end
        endcase
        if (launch)
            for (int i = 0; i < NT; i++)
                for (int k = 0; k < 8; k++) m_sh[i][k] = m_wk[i][k];
    endtask

    function automatic logic [511:0] exp_cfg();
        logic [NT*32-1:0] ea, eb, es;
        logic [NT*11-1:0] er, ec, ed;
        logic [NT*8-1:0]  ez;
        logic [NT*5-1:0]  eh;
        for (int i = 0; i < NT; i++) begin
            ea[i*32 +: 32] = m_sh[i][0];
            er[i*11 +: 11] = m_sh[i][1][10:0];
            ec[i*11 +: 11] = m_sh[i][2][10:0];
            ed[i*11 +: 11] = m_sh[i][3][10:0];
            ez[i*8  +: 8]  = m_sh[i][4][7:0];
            eb[i*32 +: 32] = m_sh[i][5];
            es[i*32 +: 32] = m_sh[i][6];
            eh[i*5  +: 5]  = m_sh[i][7][4:0];
        end
        return 512'({ea, er, ec, ed, ez, eb, es, eh});
    endfunction

    // One clock cycle: drive at negedge, check the combinational response,
    // advance the model at posedge, check registered outputs at next negedge.
    task automatic cyc(input bit sel, input bit en, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit dn,
                       output logic [31:0] rd, output logic er);
        logic [31:0] erd;
        bit eer;
        int ti, f;
        bus.psel = sel; bus.penable = en; bus.pwrite = w;
        bus.paddr = a; bus.pwdata = d; done_i = dn;
        #1;
        rd = bus.prdata; er = bus.pslverr;
        m_dec(w, a, d, eer, erd, ti, f);
        if (!(sel && en) || rst) begin eer = 0; erd = '0; end
        if (!rst) begin
            chk("prdata", 512'(rd), 512'(erd));
            chk("pslverr", 512'(er), 512'(eer));
        end
        @(posedge clk);
        m_commit(sel && en, w, a, d, dn, rst);
        @(negedge clk);
        chk("start_o", 512'(start_o), 512'(ph == 1));
        chk("busy_o", 512'(busy_o), 512'(ph != 0));
        chk("irq_o", 512'(irq_o), 512'(m_done && m_en));
        chk("cfg", 512'({cfg_addr_o, cfg_row_o, cfg_col_o, cfg_depth_o,
                         cfg_zp_o, cfg_bias_o, cfg_scale_o, cfg_shift_o}), exp_cfg());
    endtask

    task automatic apb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input bit dn, output logic [31:0] rd, output logic er);
        logic [31:0] r0;
        logic e0;
        cyc(1'b1, 1'b0, w, a, d, 1'b0, r0, e0);
        cyc(1'b1, 1'b1, w, a, d, dn, rd, er);
    endtask

    task automatic idle(input bit dn);
        logic [31:0] r0;
        logic e0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, dn, r0, e0);
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        bit          er;
    } vec_t;

    vec_t tbl [19];
    logic [31:0] rd;
    logic er;

    initial begin
        tbl[0]  = '{0, 32'h0C, 32'h0,         32'h3,         0};
        tbl[1]  = '{0, 32'h04, 32'h0,         32'h0,         0};
        tbl[2]  = '{0, 32'h98, 32'h0,         32'h0,         0};
        tbl[3]  = '{1, 32'h70, 32'hFF,        32'h0,         0};
        tbl[4]  = '{0, 32'h70, 32'h0,         32'hFFFF_FFFF, 0};
        tbl[5]  = '{1, 32'h40, 32'h1000_0000, 32'h0,         0};
        tbl[6]  = '{0, 32'h40, 32'h0,         32'h1000_0000, 0};
        tbl[7]  = '{1, 32'h44, 32'hFFFF_FFFF, 32'h0,         0};
        tbl[8]  = '{0, 32'h44, 32'h0,         32'h7FF,       0};
        tbl[9]  = '{1, 32'h94, 32'h8000_0000, 32'h0,         0};
        tbl[10] = '{0, 32'h97, 32'h0,         32'h8000_0000, 0};
        tbl[11] = '{1, 32'h9C, 32'hFFFF_FFE3, 32'h0,         0};
        tbl[12] = '{0, 32'h9C, 32'h0,         32'h3,         0};
        tbl[13] = '{0, 32'hA0, 32'h0,         32'h0,         1};
        tbl[14] = '{1, 32'h04, 32'h7,         32'h0,         1};
        tbl[15] = '{1, 32'h0C, 32'h5,         32'h0,         1};
        tbl[16] = '{0, 32'h10, 32'h0,         32'h0,         1};
        tbl[17] = '{0, 32'h08, 32'h0,         32'h0,         0};
        tbl[18] = '{0, 32'h00, 32'h0,         32'h0,         0};

        m_clear();
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0;
        @(negedge clk);
        idle(0);
        idle(0);
        rst = 1'b0;
        idle(0);
        chk("reset_start_o", 512'(start_o), 512'(0));
        chk("reset_busy_o", 512'(busy_o), 512'(0));
        chk("reset_irq_o", 512'(irq_o), 512'(0));
        chk("pready", 512'(bus.pready), 512'(1));

        for (int i = 0; i < 19; i++) begin
            apb_xfer(tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, rd, er);
            chk($sformatf("tbl%0d_rd", i), 512'(rd), 512'(tbl[i].rd));
            chk($sformatf("tbl%0d_err", i), 512'(er), 512'(tbl[i].er));
        end

        // Launch: shadow visible with the start pulse
        apb_xfer(1, 32'h0, 32'h1, 0, rd, er);
        chk("launch_start_o", 512'(start_o), 512'(1));
        chk("launch_zp_t1", 512'(cfg_zp_o[15:8]), 512'(8'hFF));
        chk("launch_addr_t0", 512'(cfg_addr_o[31:0]), 512'(32'h1000_0000));
        idle(0);
        chk("start_one_cycle", 512'(start_o), 512'(0));
        chk("busy_run", 512'(busy_o), 512'(1));

        // Shadow holds during RUN; queue a start, reject a second one
        apb_xfer(1, 32'h40, 32'h2000, 0, rd, er);
        chk("shadow_hold", 512'(cfg_addr_o[31:0]), 512'(32'h1000_0000));
        apb_xfer(1, 32'h0, 32'h1, 0, rd, er);
        chk("queue_start_err", 512'(er), 512'(0));
        apb_xfer(0, 32'h4, 32'h0, 0, rd, er);
        chk("status_pending", 512'(rd), 512'(32'h5));
        apb_xfer(1, 32'h0, 32'h1, 0, rd, er);
        chk("start_while_pending", 512'(er), 512'(1));
        idle(1);
        chk("pending_relaunch", 512'(start_o), 512'(1));
        chk("relaunch_addr_t0", 512'(cfg_addr_o[31:0]), 512'(32'h2000));
        apb_xfer(0, 32'h4, 32'h0, 0, rd, er);
        chk("status_done", 512'(rd), 512'(32'h3));

        // Interrupt enable, clear, and set-beats-clear
        apb_xfer(1, 32'h0, 32'h2, 0, rd, er);
        chk("irq_on", 512'(irq_o), 512'(1));
        apb_xfer(1, 32'h8, 32'h1, 0, rd, er);
        chk("irq_cleared", 512'(irq_o), 512'(0));
        idle(1);
        chk("irq_on_done", 512'(irq_o), 512'(1));
        chk("idle_after_done", 512'(busy_o), 512'(0));
        apb_xfer(1, 32'h8, 32'h1, 0, rd, er);
        apb_xfer(1, 32'h0, 32'h3, 0, rd, er);
        apb_xfer(1, 32'h8, 32'h1, 1, rd, er);
        chk("irq_set_wins", 512'(irq_o), 512'(1));
        apb_xfer(1, 32'h8, 32'h1, 0, rd, er);
        chk("irq_clear_alone", 512'(irq_o), 512'(0));

        // START and done_i in the same RUN cycle
        apb_xfer(1, 32'h0, 32'h3, 0, rd, er);
        apb_xfer(1, 32'h0, 32'h3, 1, rd, er);
        chk("start_done_err", 512'(er), 512'(0));
        chk("start_done_launch", 512'(start_o), 512'(1));
        // Pending job launches while a new START errors
        apb_xfer(1, 32'h0, 32'h1, 0, rd, er);
        apb_xfer(1, 32'h0, 32'h1, 1, rd, er);
        chk("pend_start_err", 512'(er), 512'(1));
        chk("pend_launch", 512'(start_o), 512'(1));

        // Errors leave state alone
        apb_xfer(1, 32'hA0, 32'hDEAD, 0, rd, er);
        chk("unmapped_err", 512'(er), 512'(1));
        apb_xfer(0, 32'h40, 32'h0, 0, rd, er);
        chk("no_change", 512'(rd), 512'(32'h2000));

        // Reset in RUN with a pending start
        apb_xfer(1, 32'h0, 32'h1, 0, rd, er);
        rst = 1'b1;
        idle(0);
        rst = 1'b0;
        chk("rst_busy", 512'(busy_o), 512'(0));
        for (int i = 0; i < 4; i++) begin
            idle(0);
            chk("rst_no_start", 512'(start_o), 512'(0));
        end
        apb_xfer(0, 32'h4, 32'h0, 0, rd, er);
        chk("rst_status", 512'(rd), 512'(0));

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, d;
            bit w, dn;
            int k;
            k  = $urandom_range(0, 9);
            d  = $urandom;
            w  = 1'($urandom_range(0, 1));
            dn = ($urandom_range(0, 3) == 0);
            case (k)
                0: begin a = 32'h0; w = 1; end
                1: a = 32'($urandom_range(0, 3) * 4);
                8: a = $urandom;
                9: a = 32'h10 + 32'($urandom_range(0, 11) * 4);
                default: a = 32'h40 + 32'($urandom_range(0, NT) * 32)
                           + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                idle(0);
                rst = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                idle(dn);
            end else begin
                apb_xfer(w, a, d, dn, rd, er);
            end
        end
        idle(0);
        idle(0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
